// File: rtl/alu_decode_stage.sv
// RV32I decode stage: one registered entry behind a valid/ready handshake.
// Each instruction is turned into an ALU op code, operand selects, an immediate and register indices.

package alu_decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic            src_a_pc,
  output logic            src_b_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic            illegal;
    logic            reg_write;
    logic            src_a_pc;
    logic            src_b_imm;
    alu_op_e         alu_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t dec;
  entry_t q;
  logic   valid_q;
  logic   accept;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

  always_comb begin
    // NOTE: every field gets a default first, so no opcode path can leave a latch behind.
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.pc     = in_pc;

    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000)
          dec.alu_op = alu_op_e'({1'b0, funct3});
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dec.alu_op = alu_op_e'({1'b1, funct3});
        else
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.imm       = sext(imm_i);
        case (funct3)
          3'b001:  if (funct7 == 7'b0000000) dec.alu_op = ALU_SLL;
                   else dec.illegal = 1'b1;
          3'b101:  if (funct7 == 7'b0000000) dec.alu_op = ALU_SRL;
                   else if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
                   else dec.illegal = 1'b1;
          // Non-shift immediates carry no funct7, so bit 30 never selects SUB.
          default: dec.alu_op = alu_op_e'({1'b0, funct3});
        endcase
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.rs1       = 5'd0;
        dec.imm       = sext(imm_u);
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.imm       = sext(imm_u);
      end
      OPC_LOAD: begin
        dec.reg_write = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.imm       = sext(imm_i);
      end
      OPC_STORE: begin
        dec.src_b_imm = 1'b1;
        dec.imm       = sext(imm_s);
      end
      OPC_BRANCH: begin
        dec.imm = sext(imm_b);
        case (funct3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec.alu_op    = ALU_ADD;
      dec.reg_write = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else begin
      // NOTE: non-blocking so the held entry and valid flag all change together at the edge.
      if (flush)          valid_q <= 1'b0;
      else if (accept) begin
        valid_q <= 1'b1;
        q       <= dec;
      end
      else if (out_ready) valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign alu_op    = q.alu_op;
  assign src_a_pc  = q.src_a_pc;
  assign src_b_imm = q.src_b_imm;
  assign imm       = q.imm;
  assign rs1       = q.rs1;
  assign rs2       = q.rs2;
  assign rd        = q.rd;
  assign reg_write = q.reg_write;
  assign illegal   = q.illegal;
  assign out_pc    = q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized and directed bench for alu_decode_stage, checked against an instruction-level model.
module tb_alu_decode_stage;
  import alu_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready, out_valid, src_a_pc, src_b_imm, reg_write, illegal;
  logic [3:0]  alu_op;
  logic [31:0] imm, out_pc;
  logic [4:0]  rs1, rs2, rd;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .src_a_pc(src_a_pc), .src_b_imm(src_b_imm), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .illegal(illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, illegal, reg_write, src_a_pc, src_b_imm;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
  } obs_t;

  int   n_checks = 0;
  int   n_fail = 0;
  logic m_valid = 1'b0;
  obs_t m_ent, m_mask, got, exp_v, msk;
  logic rdy_seen, exp_rdy;

  function automatic obs_t observe();
    obs_t o;
    o = '{out_valid, illegal, reg_write, src_a_pc, src_b_imm, alu_op, imm, rs1, rs2, rd, out_pc};
    return o;
  endfunction

  function automatic logic [3:0] op_for(input int f3, input bit alt);
    case (f3)
      0:       return alt ? ALU_SUB : ALU_ADD;
      1:       return ALU_SLL;
      2:       return ALU_SLT;
      3:       return ALU_SLTU;
      4:       return ALU_XOR;
      5:       return alt ? ALU_SRA : ALU_SRL;
      6:       return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Expected entry plus a mask of the fields the instruction class actually defines.
  function automatic void ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                     output obs_t e, output obs_t m);
    int   si, f3, f7, imm_i, imm_s, imm_b;
    logic [31:0] imm_u;
    bit   bad, wr, shift;
    obs_t base;
    logic [3:0] op;
    si = $signed(i);
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    imm_i = si >>> 20;
    imm_s = ((si >>> 25) << 5) | int'(i[11:7]);
    imm_b = ((si >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
    imm_u = i & 32'hFFFF_F000;
    e = '0; m = '0;
    e.valid = 1'b1; e.pc = pc; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    m.valid = 1'b1; m.illegal = 1'b1; m.alu_op = '1; m.reg_write = 1'b1; m.pc = '1; m.rd = '1;
    base = m;
    bad = 1'b0; wr = 1'b0; op = ALU_ADD;
    case (i[6:0])
      OPC_OP: begin
        bad = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
        op = op_for(f3, f7 == 32); wr = 1'b1;
        m.rs1 = '1; m.rs2 = '1; m.src_a_pc = 1'b1; m.src_b_imm = 1'b1;
      end
      OPC_OP_IMM: begin
        shift = (f3 == 1 || f3 == 5);
        bad = shift && !(f7 == 0 || (f3 == 5 && f7 == 32));
        op = op_for(f3, shift && f7 == 32); wr = 1'b1;
        e.imm = 32'(imm_i); e.src_b_imm = 1'b1;
        m.imm = '1; m.rs1 = '1; m.src_a_pc = 1'b1; m.src_b_imm = 1'b1;
      end
      OPC_LUI: begin
        wr = 1'b1; e.rs1 = 5'd0; e.src_b_imm = 1'b1; e.imm = imm_u;
        m.imm = '1; m.rs1 = '1; m.src_a_pc = 1'b1; m.src_b_imm = 1'b1;
      end
      OPC_AUIPC: begin
        wr = 1'b1; e.src_a_pc = 1'b1; e.src_b_imm = 1'b1; e.imm = imm_u;
        m.imm = '1; m.src_a_pc = 1'b1; m.src_b_imm = 1'b1;
      end
      OPC_LOAD: begin
        wr = 1'b1; e.src_b_imm = 1'b1; e.imm = 32'(imm_i);
        m.imm = '1; m.rs1 = '1; m.src_a_pc = 1'b1; m.src_b_imm = 1'b1;
      end
      OPC_STORE: begin
        e.src_b_imm = 1'b1; e.imm = 32'(imm_s);
        m.imm = '1; m.rs1 = '1; m.rs2 = '1; m.src_a_pc = 1'b1; m.src_b_imm = 1'b1;
      end
      OPC_BRANCH: begin
        bad = (f3 == 2 || f3 == 3);
        op = (f3 < 4) ? ALU_SUB : (f3 < 6) ? ALU_SLT : ALU_SLTU;
        e.imm = 32'(imm_b);
        m.imm = '1; m.rs1 = '1; m.rs2 = '1; m.src_a_pc = 1'b1; m.src_b_imm = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      op = ALU_ADD; wr = 1'b0; m = base;
    end
    e.illegal = bad;
    e.alu_op = op;
    e.reg_write = wr && (i[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    i[6:0] = OPC_OP;
      2, 3:    i[6:0] = OPC_OP_IMM;
      4:       i[6:0] = OPC_LUI;
      5:       i[6:0] = OPC_AUIPC;
      6:       i[6:0] = OPC_LOAD;
      7:       i[6:0] = OPC_STORE;
      8:       i[6:0] = OPC_BRANCH;
      default: i[6:0] = 7'b1101111;
    endcase
    case ($urandom_range(0, 3))
      0, 1:    i[31:25] = 7'b0000000;
      2:       i[31:25] = 7'b0100000;
      default: ;
    endcase
    return i;
  endfunction

  // Drive one cycle of inputs, sample in_ready before the edge, advance the model, sample after.
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    obs_t e, m;
    in_valid = v; in_instr = instr; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    rdy_seen = in_ready;
    exp_rdy  = !m_valid || ordy;
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (v && exp_rdy) begin
      ref_decode(instr, pc, e, m);
      m_valid = 1'b1; m_ent = e; m_mask = m;
    end
    else if (ordy) m_valid = 1'b0;
    #1;
    got = observe();
    exp_v = m_valid ? m_ent : obs_t'('0);
    msk = '0;
    msk.valid = 1'b1;
    if (m_valid) msk = m_mask;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2 got = observe();
    if (got !== obs_t'('0)) begin
      n_fail++; $display("FAIL reset_state: got %h required %h", got, obs_t'('0));
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    n_checks++;
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 32'h002081B3, 32'h0000_1000, 1'b1, 1'b0);
    if ((got & msk) !== (exp_v & msk)) begin
      n_fail++; $display("FAIL first_accept: got %h required %h", got & msk, exp_v & msk);
    end
    n_checks++;
  endtask

  task automatic test_directed();
    logic [31:0] list [5] = '{32'h002081B3, 32'hFFF00293, 32'h40208133, 32'h0000007F, 32'h00208033};
    for (int k = 0; k < 5; k++) begin
      step(1'b1, list[k], 32'h0000_2000 + 32'(4 * k), 1'b1, 1'b0);
      if ((got & msk) !== (exp_v & msk)) begin
        n_fail++; $display("FAIL directed_%0d: got %h required %h", k, got & msk, exp_v & msk);
      end
      n_checks++;
      case (k)
        0: if ({out_valid, alu_op, rs1, rs2, rd, reg_write, illegal} !==
               {1'b1, ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0}) begin
             n_fail++; $display("FAIL add_fields: op %h rs1 %0d rs2 %0d rd %0d wr %b ill %b",
                                alu_op, rs1, rs2, rd, reg_write, illegal);
           end
        1: if ({imm, src_b_imm, alu_op} !== {32'hFFFF_FFFF, 1'b1, ALU_ADD}) begin
             n_fail++; $display("FAIL addi_fields: imm %h src_b_imm %b op %h required ffffffff 1 %h",
                                imm, src_b_imm, alu_op, ALU_ADD);
           end
        2: if (alu_op !== ALU_SUB) begin
             n_fail++; $display("FAIL sub_op: got %h required %h", alu_op, ALU_SUB);
           end
        3: if ({illegal, reg_write} !== 2'b10) begin
             n_fail++; $display("FAIL illegal_fields: illegal %b reg_write %b required 1 0",
                                illegal, reg_write);
           end
        default: if (reg_write !== 1'b0) begin
             n_fail++; $display("FAIL rd0_write: got %b required 0", reg_write);
           end
      endcase
      n_checks++;
    end
  endtask

  task automatic test_stall();
    step(1'b1, 32'h00500093, 32'h0000_3000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h40315233, 32'h0000_3004, 1'b0, 1'b0);
      if (rdy_seen !== 1'b0 || (got & msk) !== (exp_v & msk)) begin
        n_fail++; $display("FAIL stall_%0d: in_ready %b got %h required 0 %h",
                           k, rdy_seen, got & msk, exp_v & msk);
      end
      n_checks++;
    end
    step(1'b1, 32'h40315233, 32'h0000_3004, 1'b1, 1'b0);
    step(1'b1, 32'h0062A023, 32'h0000_3008, 1'b1, 1'b0);
    if (rdy_seen !== 1'b1 || (got & msk) !== (exp_v & msk) || got.pc !== 32'h0000_3008) begin
      n_fail++; $display("FAIL back_to_back: in_ready %b got %h required 1 %h",
                         rdy_seen, got & msk, exp_v & msk);
    end
    n_checks++;
  endtask

  task automatic test_flush();
    step(1'b1, 32'h00A00513, 32'h0000_4000, 1'b1, 1'b0);
    step(1'b1, 32'h00B00593, 32'h0000_4004, 1'b0, 1'b1);
    if (out_valid !== 1'b0 || exp_v.valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold: out_valid %b required 0", out_valid);
    end
    n_checks++;
    step(1'b1, 32'h00C00613, 32'h0000_4008, 1'b1, 1'b0);
    step(1'b1, 32'h00D00693, 32'h0000_400C, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    if ((got & msk) !== (exp_v & msk)) begin
      n_fail++; $display("FAIL flush_accept: got %h required %h", got & msk, exp_v & msk);
    end
    n_checks++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      if (rdy_seen !== exp_rdy || (got & msk) !== (exp_v & msk)) begin
        n_fail++; $display("FAIL random_%0d: in_ready %b/%b got %h required %h",
                           k, rdy_seen, exp_rdy, got & msk, exp_v & msk);
      end
      n_checks++;
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h002081B3, 32'h0000_5000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 got = observe();
    m_valid = 1'b0;
    if (got !== obs_t'('0) || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got %h in_ready %b required 0 1", got, in_ready);
    end
    n_checks++;
    @(posedge clk);
    #1 got = observe();
    if (got !== obs_t'('0)) begin
      n_fail++; $display("FAIL reset_no_capture: got %h required 0", got);
    end
    n_checks++;
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 32'h123450B7, 32'h0000_6000, 1'b1, 1'b0);
    if ((got & msk) !== (exp_v & msk) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_accept: got %h required %h", got & msk, exp_v & msk);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
